// File: rtl/spi_burst_sequencer.sv
// spi_burst_sequencer
// Command stage that sits in front of SPIMaster. Outgoing bytes are queued in
// a small TX FIFO; a go command then runs N back-to-back single-byte SPI
// transactions and hands each received byte out on a valid/ready RX port.

module spi_burst_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int LEN_WIDTH    = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_go,
    input  logic [LEN_WIDTH-1:0]  i_len,
    output logic                  o_rx_valid,
    input  logic                  i_rx_ready,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_seq_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic                  o_m_start,
    output logic [DATA_WIDTH-1:0] o_m_data_in,
    input  logic                  i_m_busy,
    input  logic [DATA_WIDTH-1:0] i_m_data_out
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO,
        S_DELIVER
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // TX FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    // Burst bookkeeping and registered outputs
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic [TO_W-1:0]       r_timeout;
    logic [DATA_WIDTH-1:0] r_m_data_in;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_done;
    logic                  r_error;

    // Decoded control from the next-state logic
    logic w_push;
    logic w_pop;
    logic w_launch;
    logic w_capture;
    logic w_timeout_hit;
    logic w_finish;
    logic w_m_start;
    logic w_seq_busy;
    logic w_fifo_empty;

    assign o_tx_ready   = (r_count != CNT_W'(FIFO_DEPTH));
    assign w_push       = i_tx_valid && o_tx_ready;
    assign w_fifo_empty = (r_count == '0);

    assign o_rx_valid  = r_rx_valid;
    assign o_rx_data   = r_rx_data;
    assign o_seq_busy  = w_seq_busy;
    assign o_done      = r_done;
    assign o_error     = r_error;
    assign o_m_start   = w_m_start;
    assign o_m_data_in = r_m_data_in;

    // State register for the burst sequencer
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; FETCH only pops when the RX slot is free so a capture can never overrun
    always_comb begin
        w_next_state  = r_state;
        w_pop         = 1'b0;
        w_launch      = 1'b0;
        w_capture     = 1'b0;
        w_timeout_hit = 1'b0;
        w_finish      = 1'b0;
        w_m_start     = 1'b0;
        w_seq_busy    = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                w_seq_busy = 1'b0;
                if (i_go && (i_len != '0)) begin
                    w_launch     = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!w_fifo_empty && !r_rx_valid) begin
                    w_pop        = 1'b1;
                    w_next_state = S_START;
                end
            end
            S_START: begin
                w_m_start    = 1'b1;
                w_next_state = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (i_m_busy) begin
                    w_next_state = S_WAIT_LO;
                end else if (r_timeout == TO_W'(BUSY_TIMEOUT - 1)) begin
                    w_timeout_hit = 1'b1;
                    w_next_state  = S_IDLE;
                end
            end
            S_WAIT_LO: begin
                if (!i_m_busy) begin
                    w_capture    = 1'b1;
                    w_next_state = S_DELIVER;
                end
            end
            S_DELIVER: begin
                if (r_remaining == '0) begin
                    w_finish     = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // FIFO data array; contents need no reset because the count gates every read
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_tx_data;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Burst datapath: byte counter, busy-rise timeout, SPI byte staging, RX slot and status pulses
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_remaining <= '0;
            r_timeout   <= '0;
            r_m_data_in <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_done  <= w_finish;
            r_error <= w_timeout_hit;

            if (w_launch) begin
                r_remaining <= i_len;
            end else if (w_timeout_hit) begin
                r_remaining <= '0;
            end else if (w_capture) begin
                r_remaining <= r_remaining - 1'b1;
            end

            if (r_state == S_START) begin
                r_timeout <= '0;
            end else if (r_state == S_WAIT_HI && !i_m_busy) begin
                r_timeout <= r_timeout + 1'b1;
            end

            if (w_pop) begin
                r_m_data_in <= r_mem[r_rd_ptr];
            end

            if (w_capture) begin
                r_rx_data  <= i_m_data_out;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && i_rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/spi_burst_sequencer.md
Name: spi_burst_sequencer

Overview:
- Upstream command stage for SPIMaster. Buffers outgoing bytes in a small TX FIFO and, on a `go` command, issues N back-to-back single-byte transactions to SPIMaster through its start/data_in/busy/data_out handshake.
- Returns each received byte on a valid/ready RX port.
- Lets firmware-side logic issue multi-byte bursts (e.g. flash command + address + data) without per-byte sequencing.

Parameters:
- DATA_WIDTH, 8, width of each SPI byte; must match SPIMaster DATA_WIDTH.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, at least 2.
- LEN_WIDTH, 8, width of the burst-length field.
- BUSY_TIMEOUT, 16, cycles allowed between m_start and m_busy rising before the burst aborts.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- tx_valid  input  1  TX byte offered
- tx_ready  output  1  TX FIFO not full
- tx_data  input  DATA_WIDTH  byte to transmit
- go  input  1  burst request; sampled only in IDLE
- len  input  LEN_WIDTH  number of bytes in the burst; sampled with go
- rx_valid  output  1  received byte available
- rx_ready  input  1  consumer accepts the RX byte
- rx_data  output  DATA_WIDTH  received byte
- seq_busy  output  1  burst in progress
- done  output  1  one-cycle pulse when a burst completes normally
- error  output  1  one-cycle pulse when a burst aborts on timeout
- m_start  output  1  to SPIMaster start
- m_data_in  output  DATA_WIDTH  to SPIMaster data_in
- m_busy  input  1  from SPIMaster busy
- m_data_out  input  DATA_WIDTH  from SPIMaster data_out

Behaviour:
- Reset (synchronous, active-high): all state is cleared on the clock edge while reset=1.
  - FIFO empties: pointers 0, count 0.
  - FSM goes to IDLE.
  - tx_ready=1, rx_valid=0, rx_data=0, seq_busy=0, done=0, error=0, m_start=0, m_data_in=0.
- TX FIFO:
  - A write occurs when tx_valid && tx_ready. tx_ready = (count != FIFO_DEPTH).
  - Pointers wrap modulo FIFO_DEPTH.
  - A simultaneous write and read while full is not allowed, because tx_ready=0.
  - A simultaneous write and read at any other level leaves count unchanged.
  - Writes are accepted in every FSM state.
- FSM states: IDLE, FETCH, START, WAIT_HI, WAIT_LO, DELIVER.
  - IDLE: go && len!=0 latches remaining=len and moves to FETCH. go with len==0 is ignored: no pulse, stays IDLE. seq_busy=0 only in IDLE.
  - FETCH:
    - If the FIFO is non-empty and rx_valid==0, pop the head into m_data_in and go to START.
    - Otherwise stall in FETCH. FIFO underrun and an unconsumed RX byte both stall; neither is an error.
  - START: m_start=1 for exactly this one cycle. Clear the timeout counter and go to WAIT_HI.
  - WAIT_HI:
    - m_busy==1 moves to WAIT_LO.
    - Otherwise increment the timeout counter. When it reaches BUSY_TIMEOUT: pulse error, clear remaining, go to IDLE. The FIFO contents are kept.
  - WAIT_LO: m_busy==0 captures m_data_out into rx_data, sets rx_valid=1, decrements remaining, and goes to DELIVER.
  - DELIVER:
    - remaining==0: pulse done and go to IDLE.
    - Otherwise go to FETCH.
- Per-byte overhead outside SPIMaster time: 3 cycles (FETCH, START, DELIVER), plus the FIFO and RX stalls described above.
- RX port:
  - rx_valid clears on the cycle after rx_valid && rx_ready.
  - rx_data is held stable while rx_valid=1.
  - Capture only ever happens when rx_valid==0, guaranteed by the FETCH gating. No RX overrun is possible.
- go outside IDLE is ignored.
- done and error are never asserted in the same cycle.
- Reset mid-burst: immediate return to IDLE with all outputs at their reset values. SPIMaster is reset from the same reset.

Test Plan:
1. Write A5, 3C, F0; go len=3. SPIMaster model loops MOSI back to MISO → three m_start pulses; rx_data sequence A5, 3C, F0 with rx_ready=1; done pulses once; seq_busy falls the same cycle done is seen.
2. Write 5 bytes back-to-back, FIFO_DEPTH=4 → tx_ready=0 after the 4th write; the 5th is accepted only after go len=1 pops one entry; final count=4.
3. go len=2 with rx_ready=0 → after byte 1, rx_valid=1 and no second m_start is issued. Raise rx_ready → byte 2 starts within 3 cycles; done follows.
4. go len=0 → no state change, no done. go len=2 with FIFO empty → stalls in FETCH with m_start=0; writing 2 bytes resumes the burst to done.
5. Model holds m_busy=0 → error pulses exactly BUSY_TIMEOUT cycles after WAIT_HI entry; returns to IDLE; remaining FIFO bytes are still present.
6. Assert reset during WAIT_LO of byte 2 of 4 → next cycle all outputs at reset values, FIFO count=0; a new burst afterwards completes normally.
